// File: rtl/shiftreg_param_burst.sv
// Parametrised shift/rotate register with a counted burst engine.
// Single-step shifts in IDLE use the live Mode; bursts latch Mode and Amount on Start.
module shiftreg_param_burst #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CW        = $clog2(WIDTH + 1) + 1
) (
    input  logic             Clock,
    input  logic             Aclr,
    input  logic             Sclr,
    input  logic             Enable,
    input  logic             Load,
    input  logic [WIDTH-1:0] Data,
    input  logic [2:0]       Mode,
    input  logic             ShiftIn,
    input  logic             Start,
    input  logic [CW-1:0]    Amount,
    output logic [WIDTH-1:0] Q,
    output logic             ShiftOut,
    output logic             Busy,
    output logic             Done,
    output logic [CW-1:0]    Count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_mode;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_q;
    logic             r_done;

    state_t           w_state_nxt;
    logic [2:0]       w_mode_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_done_nxt;
    logic [2:0]       w_eff_mode;

    // One shift step; codes 101..111 leave the value untouched.
    function automatic logic [WIDTH-1:0] f_shift(
        input logic [WIDTH-1:0] q,
        input logic [2:0]       m,
        input logic             si
    );
        logic [WIDTH-1:0] res;
        case (m)
            3'b000:  res = {q[WIDTH-2:0], si};
            3'b001:  res = {si, q[WIDTH-1:1]};
            3'b010:  res = {q[WIDTH-2:0], q[WIDTH-1]};
            3'b011:  res = {q[0], q[WIDTH-1:1]};
            3'b100:  res = {q[WIDTH-1], q[WIDTH-1:1]};
            default: res = q;
        endcase
        return res;
    endfunction

    function automatic logic f_shift_out(
        input logic [WIDTH-1:0] q,
        input logic [2:0]       m
    );
        logic bit_out;
        case (m)
            3'b000, 3'b010:         bit_out = q[WIDTH-1];
            3'b001, 3'b011, 3'b100: bit_out = q[0];
            default:                bit_out = 1'b0;
        endcase
        return bit_out;
    endfunction

    assign w_eff_mode = (r_state == S_RUN) ? r_mode : Mode;

    always_ff @(posedge Clock or negedge Aclr) begin
        if (!Aclr) begin
            r_state <= S_IDLE;
            r_mode  <= 3'b000;
            r_count <= '0;
            r_q     <= RESET_VAL;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_count <= w_count_nxt;
            r_q     <= w_q_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Priority: Sclr, Load, Start-in-IDLE, Enable, hold.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_count_nxt = r_count;
        w_q_nxt     = r_q;
        w_done_nxt  = 1'b0;

        if (Sclr) begin
            w_q_nxt     = RESET_VAL;
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else if (Load) begin
            w_q_nxt     = Data;
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else if ((r_state == S_IDLE) && Start) begin
            if (Amount != '0) begin
                w_mode_nxt  = Mode;
                w_count_nxt = Amount;
                w_state_nxt = S_RUN;
            end else begin
                w_done_nxt  = 1'b1;
            end
        end else if (Enable) begin
            w_q_nxt = f_shift(r_q, w_eff_mode, ShiftIn);
            if (r_state == S_RUN) begin
                w_count_nxt = r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
        end
    end

    assign Q        = r_q;
    assign ShiftOut = f_shift_out(r_q, w_eff_mode);
    assign Busy     = (r_state == S_RUN);
    assign Done     = r_done;
    assign Count    = r_count;

endmodule

// File: tb/tb_shiftreg_param_burst.sv
// Directed bench for shiftreg_param_burst: burst results are queued as expectations
// and checked by a monitor whenever Done pulses; immediate state is checked inline.
module tb_shiftreg_param_burst;

    localparam int W  = 16;
    localparam int CW = $clog2(W + 1) + 1;

    logic          Clock = 1'b0;
    logic          Aclr, Sclr, Enable, Load, ShiftIn, Start;
    logic [W-1:0]  Data;
    logic [2:0]    Mode;
    logic [CW-1:0] Amount;
    logic [W-1:0]  Q;
    logic          ShiftOut, Busy, Done;
    logic [CW-1:0] Count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string        nm;
        logic [W-1:0] q;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    shiftreg_param_burst #(
        .WIDTH     (W),
        .RESET_VAL (16'hA5A5)
    ) dut (
        .Clock    (Clock),
        .Aclr     (Aclr),
        .Sclr     (Sclr),
        .Enable   (Enable),
        .Load     (Load),
        .Data     (Data),
        .Mode     (Mode),
        .ShiftIn  (ShiftIn),
        .Start    (Start),
        .Amount   (Amount),
        .Q        (Q),
        .ShiftOut (ShiftOut),
        .Busy     (Busy),
        .Done     (Done),
        .Count    (Count)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic load(input logic [W-1:0] v);
        Load = 1'b1;
        Data = v;
        step();
        Load = 1'b0;
    endtask

    task automatic start_burst(input logic [2:0] m, input int amt, input logic si);
        Mode    = m;
        Amount  = CW'(amt);
        ShiftIn = si;
        Start   = 1'b1;
        Enable  = 1'b1;
        step();
        Start   = 1'b0;
    endtask

    // Monitor: every Done pulse must match the oldest queued burst result.
    always @(negedge Clock) begin
        if (Aclr && Done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(Done), 64'(0));
            end else begin
                e = sb.pop_front();
                chk({e.nm, "_q"}, 64'(Q), 64'(e.q));
                chk({e.nm, "_count"}, 64'(Count), 64'(0));
                chk({e.nm, "_busy"}, 64'(Busy), 64'(0));
            end
        end
    end

    initial begin
        Aclr = 1'b0; Sclr = 1'b0; Enable = 1'b0; Load = 1'b0; ShiftIn = 1'b0;
        Start = 1'b0; Data = '0; Mode = 3'b000; Amount = '0;
        @(negedge Clock);
        @(negedge Clock);
        chk("rst_q", 64'(Q), 64'(16'hA5A5));
        chk("rst_busy", 64'(Busy), 64'(0));
        chk("rst_done", 64'(Done), 64'(0));
        chk("rst_count", 64'(Count), 64'(0));
        Aclr = 1'b1;
        step();

        // Single-step SHL then ROR
        load(16'h8001);
        Mode = 3'b000; ShiftIn = 1'b1; Enable = 1'b1;
        #1 chk("so_shl", 64'(ShiftOut), 64'(1));
        step();
        Enable = 1'b0;
        chk("single_shl", 64'(Q), 64'(16'h0003));
        Mode = 3'b011;
        #1 chk("so_ror", 64'(ShiftOut), 64'(1));
        Enable = 1'b1;
        step();
        Enable = 1'b0;
        chk("single_ror", 64'(Q), 64'(16'h8001));
        Mode = 3'b101;
        #1 chk("so_hold", 64'(ShiftOut), 64'(0));
        Enable = 1'b1;
        step();
        Enable = 1'b0;
        chk("single_hold", 64'(Q), 64'(16'h8001));

        // Burst ROL by 4; Mode changes during RUN must be ignored
        load(16'h1234);
        sb.push_back('{"rol4", 16'h2341});
        start_burst(3'b010, 4, 1'b0);
        chk("rol4_start_busy", 64'(Busy), 64'(1));
        chk("rol4_start_count", 64'(Count), 64'(4));
        chk("rol4_start_q", 64'(Q), 64'(16'h1234));
        Mode = 3'b001;
        repeat (3) step();
        chk("rol4_mid_count", 64'(Count), 64'(1));
        chk("rol4_mid_busy", 64'(Busy), 64'(1));
        step();
        Enable = 1'b0;
        step();

        // ASR burst with a one-cycle pause
        load(16'h8000);
        sb.push_back('{"asr3", 16'hF000});
        start_burst(3'b100, 3, 1'b0);
        step();
        Enable = 1'b0;
        step();
        chk("asr_pause_q", 64'(Q), 64'(16'hC000));
        chk("asr_pause_count", 64'(Count), 64'(2));
        chk("asr_pause_busy", 64'(Busy), 64'(1));
        Enable = 1'b1;
        repeat (2) step();
        Enable = 1'b0;
        step();

        // Abort by Load: no Done may follow
        start_burst(3'b000, 10, 1'b1);
        repeat (2) step();
        load(16'h00FF);
        Enable = 1'b0;
        chk("abort_q", 64'(Q), 64'(16'h00FF));
        chk("abort_busy", 64'(Busy), 64'(0));
        chk("abort_count", 64'(Count), 64'(0));
        repeat (12) step();

        // Amount=0: Done next cycle, no shift even with Enable high
        sb.push_back('{"amt0", 16'h00FF});
        start_burst(3'b000, 0, 1'b0);
        Enable = 1'b0;
        chk("amt0_busy", 64'(Busy), 64'(0));
        step();

        // Start during Busy ignored, then back-to-back Start in the Done cycle
        sb.push_back('{"ror2", 16'hC03F});
        sb.push_back('{"b2b_rol5", 16'h07F8});
        Mode = 3'b011; Amount = CW'(2); Start = 1'b1; Enable = 1'b1;
        step();
        Mode = 3'b010; Amount = CW'(5);
        step();
        chk("busy_start_count", 64'(Count), 64'(1));
        step();
        step();
        Start = 1'b0;
        chk("b2b_busy", 64'(Busy), 64'(1));
        chk("b2b_count", 64'(Count), 64'(5));
        repeat (5) step();
        Enable = 1'b0;
        step();

        // Amount beyond WIDTH: SHL with ShiftIn=0 clears everything
        load(16'hFFFF);
        sb.push_back('{"shl17", 16'h0000});
        start_burst(3'b000, 17, 1'b0);
        chk("shl17_count", 64'(Count), 64'(17));
        repeat (17) step();
        Enable = 1'b0;
        step();

        // Sclr mid-burst
        load(16'h1234);
        start_burst(3'b010, 6, 1'b0);
        step();
        Sclr = 1'b1;
        step();
        Sclr = 1'b0;
        Enable = 1'b0;
        chk("sclr_q", 64'(Q), 64'(16'hA5A5));
        chk("sclr_busy", 64'(Busy), 64'(0));
        chk("sclr_count", 64'(Count), 64'(0));
        repeat (8) step();

        // Aclr mid-burst, asserted between edges
        load(16'h1234);
        start_burst(3'b010, 6, 1'b0);
        step();
        #2 Aclr = 1'b0;
        #1;
        chk("aclr_q", 64'(Q), 64'(16'hA5A5));
        chk("aclr_busy", 64'(Busy), 64'(0));
        chk("aclr_count", 64'(Count), 64'(0));
        chk("aclr_done", 64'(Done), 64'(0));
        Enable = 1'b0;
        @(negedge Clock);
        Aclr = 1'b1;
        repeat (8) step();

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
